// File: rtl/gpi_pkg.sv
// rtl/gpi_pkg.sv - shared constants for the general-purpose input port
//
// Purpose: register word addresses, slot data width and the debounce counter
// width helper used by gpi_capture and gpi_debounce.
// Ports: none (package).
package gpi_pkg;

   localparam int unsigned GPI_DW = 32;

   localparam logic [2:0] GPI_DATA   = 3'd0;
   localparam logic [2:0] GPI_RISE   = 3'd1;
   localparam logic [2:0] GPI_FALL   = 3'd2;
   localparam logic [2:0] GPI_IRQ_EN = 3'd3;
   localparam logic [2:0] GPI_RAW    = 3'd4;

   // Counter width for a debounce of n clocks: $clog2(n), never below 1 bit.
   function automatic int unsigned gpi_cnt_width(input int unsigned n);
      return (n < 3) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/gpi_debounce.sv
// rtl/gpi_debounce.sv - one-bit input filter for gpi_capture
//
// Purpose: filters one synchronized input bit. With GPI_DEBOUNCE_EN defined the
// bit must differ from the filtered value for DB_CYCLES consecutive clocks
// before the filtered value follows it; otherwise the bit passes straight
// through.
// Macro: GPI_DEBOUNCE_EN selects the counting filter.
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high reset
//   s2     in   synchronizer output bit
//   stable out  next filtered value (the value the filtered register takes at
//               the coming edge); gpi_capture registers it next to its edge
//               flags so a flag sets on the same edge the data changes
module gpi_debounce
   import gpi_pkg::*;
#(
   parameter int unsigned DB_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic s2,
   output logic stable
);

`ifdef GPI_DEBOUNCE_EN
   localparam int unsigned         CW       = gpi_cnt_width(DB_CYCLES);
   localparam logic [CW-1:0]       CNT_LAST = CW'(DB_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          stable_q, stable_d;

   // The counter clears whenever input and filtered value agree, and also on
   // the clock it hands the new value over, so it never wraps.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      if (s2 == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         stable_d = s2;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= '0;
         stable_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   assign stable = reset ? 1'b0 : stable_d;
`else
   localparam int unsigned unused_db_cycles = DB_CYCLES;

   logic unused_clk;
   assign unused_clk = clk;

   assign stable = reset ? 1'b0 : s2;
`endif

endmodule

// File: rtl/gpi_capture.sv
// rtl/gpi_capture.sv - slot-bus general-purpose input port with edge flags and irq
//
// Purpose: synchronizes a W-bit asynchronous input (2 flops), filters it per
// bit through gpi_debounce, records rising/falling edges of the filtered value
// in sticky write-1-to-clear flags and raises a registered, maskable level
// interrupt.
// Macro: GPI_DEBOUNCE_EN enables the DB_CYCLES debounce counters (default off:
// filtered value follows the synchronizer every clock).
// Registers (addr[2:0]): 0 DATA ro, 1 RISE w1c, 2 FALL w1c, 3 IRQ_EN rw,
// 4 RAW ro, 5-7 read 0.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous, active-high reset
//   cs       in   slot select
//   read     in   read strobe (reads have no side effects)
//   write    in   write strobe
//   addr     in   register word address, addr[4:3] ignored
//   wr_data  in   write data
//   rd_data  out  read data, combinational
//   din      in   asynchronous external input
//   irq      out  registered level interrupt
module gpi_capture
   import gpi_pkg::*;
#(
   parameter int unsigned W         = 8,
   parameter int unsigned DB_CYCLES = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cs,
   input  logic              read,
   input  logic              write,
   input  logic [4:0]        addr,
   input  logic [GPI_DW-1:0] wr_data,
   output logic [GPI_DW-1:0] rd_data,
   input  logic [W-1:0]      din,
   output logic              irq
);

   logic [W-1:0] s1_q, s2_q;
   logic [W-1:0] stable_q, stable_d;
   logic [W-1:0] rise_q, rise_d;
   logic [W-1:0] fall_q, fall_d;
   logic [W-1:0] irq_en_q, irq_en_d;
   logic         irq_q, irq_d;
   logic         wr_en;
   logic [W-1:0] wr_bits;

   logic unused_slot;
   assign unused_slot = ^{read, addr[4:3], wr_data};

   for (genvar i = 0; i < W; i++) begin : g_filt
      gpi_debounce #(
         .DB_CYCLES(DB_CYCLES)
      ) u_filt (
         .clk   (clk),
         .reset (reset),
         .s2    (s2_q[i]),
         .stable(stable_d[i])
      );
   end

   assign wr_en   = cs && write;
   assign wr_bits = wr_data[W-1:0];

   // W1C is applied first and new edges are OR-ed in afterwards, so an edge
   // arriving on the same clock as its clear leaves the flag set.
   always_comb begin
      rise_d   = rise_q;
      fall_d   = fall_q;
      irq_en_d = irq_en_q;
      if (wr_en) begin
         case (addr[2:0])
            GPI_RISE:   rise_d   = rise_q & ~wr_bits;
            GPI_FALL:   fall_d   = fall_q & ~wr_bits;
            GPI_IRQ_EN: irq_en_d = wr_bits;
            default: ;
         endcase
      end
      rise_d = rise_d | (stable_d & ~stable_q);
      fall_d = fall_d | (~stable_d & stable_q);
      irq_d  = |((rise_q | fall_q) & irq_en_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q     <= '0;
         s2_q     <= '0;
         stable_q <= '0;
         rise_q   <= '0;
         fall_q   <= '0;
         irq_en_q <= '0;
         irq_q    <= 1'b0;
      end else begin
         s1_q     <= din;
         s2_q     <= s1_q;
         stable_q <= stable_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         irq_en_q <= irq_en_d;
         irq_q    <= irq_d;
      end
   end

   always_comb begin
      rd_data = '0;
      case (addr[2:0])
         GPI_DATA:   rd_data[W-1:0] = stable_q;
         GPI_RISE:   rd_data[W-1:0] = rise_q;
         GPI_FALL:   rd_data[W-1:0] = fall_q;
         GPI_IRQ_EN: rd_data[W-1:0] = irq_en_q;
         GPI_RAW:    rd_data[W-1:0] = s2_q;
         default: ;
      endcase
   end

   assign irq = irq_q;

endmodule
